// File: rtl/serial_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_mult_pkg
// Brief   : Shared state encoding, frame constants and qualifier layout for
//           the serial multiplier datapath.
// Revision: 1.0 - initial release
// ============================================================================
package serial_mult_pkg;

    localparam int LEN_W = 8;

    localparam logic [2:0] ST_CAPTURE = 3'b001;
    localparam logic [2:0] ST_MULT    = 3'b010;
    localparam logic [2:0] ST_DONE    = 3'b100;

    // Same bit order as the control FSM's packed qualifier output
    typedef struct packed {
        logic length;
        logic multiplier;
        logic multiplicand;
    } qual_t;

endpackage : serial_mult_pkg
`default_nettype wire

// File: rtl/serial_field_sr.sv
`default_nettype none
// ============================================================================
// Module  : serial_field_sr
// Brief   : MSB-first deserializing shift register with shift enable and
//           synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module serial_field_sr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule : serial_field_sr
`default_nettype wire

// File: rtl/serial_mult_dp.sv
`default_nettype none
// ============================================================================
// Module  : serial_mult_dp
// Brief   : Deserializes length/multiplier/multiplicand fields, runs a
//           shift-add multiply and returns the product over valid/ready.
//           Define SERIAL_MULT_EARLY_TERM_EN to stop after eff_len iterations.
// Revision: 1.0 - initial release
// ============================================================================
module serial_mult_dp
    import serial_mult_pkg::*;
#(
    parameter int MAX_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 length_bit,
    input  logic                 multiplier_bit,
    input  logic                 multiplicand_bit,
    input  logic                 prod_ready,
    output logic                 prod_valid,
    output logic [2*MAX_W-1:0]   product,
    output logic [LEN_W-1:0]     mult_len,
    output logic                 busy,
    output logic                 err_len,
    output logic                 overrun
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_W);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    qual_t              w_qual;
    logic               w_in_cap;
    logic               w_one_qual;
    logic               w_cap_len;
    logic               w_cap_mplr;
    logic               w_cap_mcnd;
    logic               w_clr_fields;
    logic               w_eof;
    logic               w_len_bad;
    logic               w_skip_mult;
    logic               w_last_iter;
    logic [LEN_W-1:0]   w_n_iter;
    logic [LEN_W-1:0]   w_len_sr;
    logic [MAX_W-1:0]   w_mplr;
    logic [MAX_W-1:0]   w_mcnd;
    logic [2*MAX_W-1:0] w_acc_sum;

    logic               r_mcnd_q;
    logic               r_first_len;
    logic [LEN_W-1:0]   r_iter;
    logic [2*MAX_W-1:0] r_acc;
    logic [MAX_W-1:0]   r_mplr_work;
    logic [2*MAX_W-1:0] r_mcnd_sh;

    assign w_qual       = {length_bit, multiplier_bit, multiplicand_bit};
    assign w_in_cap     = (r_state == ST_CAPTURE);
    assign w_one_qual   = $onehot(w_qual);
    assign w_cap_len    = w_in_cap && w_one_qual && w_qual.length;
    assign w_cap_mplr   = w_in_cap && w_one_qual && w_qual.multiplier;
    assign w_cap_mcnd   = w_in_cap && w_one_qual && w_qual.multiplicand;
    assign w_clr_fields = w_cap_len && r_first_len;
    assign w_eof        = w_in_cap && r_mcnd_q && !multiplicand_bit;
    assign w_len_bad    = (w_len_sr > C_MAX_LEN) || (w_len_sr == '0);
    assign w_last_iter  = (r_iter == w_n_iter - 1'b1);
    assign w_acc_sum    = r_acc + (r_mplr_work[0] ? r_mcnd_sh : '0);

    serial_field_sr #(.WIDTH(LEN_W)) u_len_sr (
        .clk(clk), .rst(rst), .clr(1'b0), .shift_en(w_cap_len),
        .din(serial_in), .q(w_len_sr)
    );

    serial_field_sr #(.WIDTH(MAX_W)) u_mplr_sr (
        .clk(clk), .rst(rst), .clr(w_clr_fields), .shift_en(w_cap_mplr),
        .din(serial_in), .q(w_mplr)
    );

    serial_field_sr #(.WIDTH(MAX_W)) u_mcnd_sr (
        .clk(clk), .rst(rst), .clr(w_clr_fields), .shift_en(w_cap_mcnd),
        .din(serial_in), .q(w_mcnd)
    );

`ifdef SERIAL_MULT_EARLY_TERM_EN
    logic [LEN_W-1:0] w_eff_len;
    logic [LEN_W-1:0] r_n_iter;

    assign w_eff_len   = (w_len_sr > C_MAX_LEN) ? C_MAX_LEN : w_len_sr;
    assign w_skip_mult = (w_eff_len == '0);
    assign w_n_iter    = r_n_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_iter <= '0;
        end else if (w_eof) begin
            r_n_iter <= w_eff_len;
        end
    end
`else
    assign w_skip_mult = 1'b0;
    assign w_n_iter    = C_MAX_LEN;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CAPTURE: if (w_eof)       w_state_nxt = w_skip_mult ? ST_DONE : ST_MULT;
            ST_MULT:    if (w_last_iter) w_state_nxt = ST_DONE;
            ST_DONE:    if (prod_ready)  w_state_nxt = ST_CAPTURE;
            default:                     w_state_nxt = ST_CAPTURE;
        endcase
    end

    always_comb begin
        busy       = (r_state != ST_CAPTURE);
        prod_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcnd_q    <= 1'b0;
            r_first_len <= 1'b1;
            r_iter      <= '0;
            r_acc       <= '0;
            r_mplr_work <= '0;
            r_mcnd_sh   <= '0;
            product     <= '0;
            mult_len    <= '0;
            err_len     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_mcnd_q <= multiplicand_bit;
            if (!w_in_cap && (w_qual != '0)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                ST_CAPTURE: begin
                    if (w_cap_len) begin
                        r_first_len <= 1'b0;
                    end
                    if (w_eof) begin
                        mult_len    <= w_len_sr;
                        r_iter      <= '0;
                        r_acc       <= '0;
                        r_mplr_work <= w_mplr;
                        r_mcnd_sh   <= {{MAX_W{1'b0}}, w_mcnd};
                        if (w_len_bad) begin
                            err_len <= 1'b1;
                        end
                        if (w_skip_mult) begin
                            product <= '0;
                        end
                    end
                end
                ST_MULT: begin
                    r_acc       <= w_acc_sum;
                    r_mplr_work <= r_mplr_work >> 1;
                    r_mcnd_sh   <= r_mcnd_sh << 1;
                    r_iter      <= r_iter + 1'b1;
                    if (w_last_iter) begin
                        product <= w_acc_sum;
                    end
                end
                ST_DONE: begin
                    if (prod_ready) begin
                        r_first_len <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_mult_dp
`default_nettype wire

// File: doc/serial_mult_dp.md
Name: serial_mult_dp

Overview:
Serial-frame datapath that sits directly downstream of the serial multiplier control FSM. It consumes the serial data bit together with the FSM's one-hot field qualifiers (length / multiplier / multiplicand) and deserializes each field. At end of frame it runs an iterative shift-add multiply and presents the product on a valid/ready output port.

Parameters:
MAX_W, 24, maximum operand width in bits (multiplier and multiplicand registers)
LEN_W, 8, width of the serial length field (fixed by frame format)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial frame data, MSB-first per field
length_bit  input  1  qualifier: serial_in belongs to length field
multiplier_bit  input  1  qualifier: serial_in belongs to multiplier field
multiplicand_bit  input  1  qualifier: serial_in belongs to multiplicand field
prod_ready  input  1  downstream accepts product
prod_valid  output  1  product valid
product  output  2*MAX_W  unsigned product
mult_len  output  LEN_W  captured length field
busy  output  1  high in MULT or DONE
err_len  output  1  sticky: length > MAX_W or length == 0
overrun  output  1  sticky: qualifier high while busy

Behaviour:
- Reset values: all outputs 0; all internal shift registers, accumulator and counters 0; state CAPTURE.
- Reset wins over every other event, including mid-multiply and mid-handshake. The in-flight frame or product is discarded.
- States: CAPTURE, MULT, DONE.
- CAPTURE, field capture:
  - On the first length_bit cycle after entering CAPTURE, clear the multiplier and multiplicand registers.
  - length_bit=1: len_sr <= {len_sr[LEN_W-2:0], serial_in}.
  - multiplier_bit=1: mplr <= {mplr[MAX_W-2:0], serial_in}.
  - multiplicand_bit=1: mcnd <= {mcnd[MAX_W-2:0], serial_in}. Excess leading bits fall off the top, so only the last MAX_W bits are kept.
  - More than one qualifier high in a cycle: no register updates that cycle.
- End of frame = multiplicand_bit registered high last cycle and low this cycle.
  - On end of frame, go to MULT.
  - mult_len <= len_sr.
  - Effective length eff_len = min(len_sr, MAX_W). If len_sr > MAX_W or len_sr == 0, set err_len. eff_len is then MAX_W, or 0 in the zero case.
  - An empty multiplier field leaves mplr = 0.
- MULT:
  - acc cleared on entry; iteration counter i counts 0..N-1.
  - Each cycle: if mplr[0] then acc <= acc + (mcnd << i); mplr >>= 1; i <= i + 1.
  - Accumulator width is 2*MAX_W; no overflow is possible.
  - N = MAX_W without the optional feature.
  - After iteration N-1: product <= acc (including the final add), go to DONE.
  - Entry to DONE with prod_valid=1 occurs exactly N+1 cycles after the end-of-frame cycle.
- DONE:
  - prod_valid=1; product held stable.
  - When prod_valid & prod_ready: prod_valid <= 0 next cycle, go to CAPTURE.
  - prod_ready may be high before valid; the handshake completes in the first DONE cycle.
- Overrun: any qualifier high while in MULT or DONE sets overrun. The bit is ignored and not captured.
- Sticky flags clear only on rst.
- busy = (state != CAPTURE).

Optional Feature:
SERIAL_MULT_EARLY_TERM_EN
- Defined: N = eff_len, so MULT takes eff_len cycles. If eff_len == 0, MULT is skipped: product = 0 and DONE is entered the cycle after end of frame.
- Undefined: N = MAX_W always, giving fixed latency. The result is identical because high multiplier bits are zero.

Decomposition:
- Shared package serial_mult_pkg holds:
  - state encoding constants ST_CAPTURE / ST_MULT / ST_DONE (one-hot, 3 bits);
  - LEN_W = 8;
  - the frame qualifier ordering {length, multiplier, multiplicand}, matching the control FSM's packed output.
- One natural sub-module: serial_field_sr. It is a parameterized width shift register with a shift-enable and synchronous clear, instantiated three times.
- The multiply loop stays in the top module.

Test Plan:
- Basic frame: len=4; multiplier bits 1011 (11); multiplicand 20 bits = 13 → mult_len=4, product=143, prod_valid 25 cycles after end of frame (MAX_W=24).
- Back-pressure: prod_ready held 0 for 10 cycles after valid → product stays 143 and valid stays 1; ready pulse → valid drops next cycle, busy=0.
- Zero multiplier: len=3, bits 000, multiplicand 0xFFFFF → product=0, err_len=0.
- Bad length: len=30 → err_len=1, eff_len=24. With SERIAL_MULT_EARLY_TERM_EN, MULT lasts exactly 24 cycles.
- Overrun plus reset: new length_bit burst during MULT → overrun=1 and product unaffected; then rst asserted mid-MULT → all outputs 0, state CAPTURE, next frame (len=2, 11×5) → product=15.
